// File: rtl/iir_biquad_cascade_if.sv
// Sample-stream handshake bundle for iir_biquad_cascade: input samples in,
// filtered samples out. The filter connects through the slave modport,
// the sample source/sink through the master modport.
interface iir_biquad_cascade_if #(
  parameter int DATA_W = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Cascade of NUM_SECTIONS Direct Form I biquads sharing one multiply-accumulate
// engine. Each section takes 5 MAC cycles plus one write-back cycle.
// Optional feature macro: IIR_SAT_EN -- when defined, every narrowing to
// DATA_W saturates; otherwise it wraps (keeps the low DATA_W bits).
module iir_biquad_cascade #(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 32,
  parameter int COEF_FRAC    = 16,
  parameter int NUM_SECTIONS = 2,
  localparam int NCOEF  = 5 * NUM_SECTIONS,
  localparam int ADDR_W = $clog2(NCOEF)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  iir_biquad_cascade_if.slave s_if,
  input  logic              coef_we_i,
  input  logic [ADDR_W-1:0] coef_addr_i,
  input  logic [COEF_W-1:0] coef_data_i,
  output logic              coef_err_o,
  output logic              busy_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [SEC_W-1:0]         sec_q;
  logic [2:0]               tap_q;
  logic signed [DATA_W-1:0] x_q;       // input of the section being computed
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        out_data_q;
  logic                     coef_err_q;

  logic signed [DATA_W-1:0] x1_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x2_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y1_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y2_q [NUM_SECTIONS];
  logic signed [COEF_W-1:0] coef_q [NCOEF];

  logic                     last_sec;
  logic                     coef_ok;
  logic [ADDR_W-1:0]        coef_idx;
  logic signed [DATA_W-1:0] mac_x;
  logic signed [COEF_W-1:0] mac_c;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] y_nar;

  // Notch defaults: b0=1.0, b1=-1.902, b2=1.0, a1=-1.883, a2=0.9801 (Q16.16)
  function automatic logic [COEF_W-1:0] default_coef(input int idx);
    logic [COEF_W-1:0] c;
    case (idx % 5)
      0, 2:    c = COEF_W'(32'sh0001_0000);
      1:       c = COEF_W'(32'shFFFE_1917);
      3:       c = COEF_W'(32'shFFFE_1DF4);
      default: c = COEF_W'(32'sh0000_FAE7);
    endcase
    return c;
  endfunction

  assign last_sec   = (sec_q == SEC_W'(NUM_SECTIONS - 1));
  assign coef_ok    = coef_we_i && (state_q == S_IDLE) && !s_if.in_valid_i &&
                      (coef_addr_i < ADDR_W'(NCOEF));
  assign coef_idx   = ADDR_W'(32'(sec_q) * 32'd5 + 32'(tap_q));

  assign s_if.in_ready_o  = (state_q == S_IDLE);
  assign s_if.out_valid_o = (state_q == S_OUT);
  assign s_if.out_data_o  = out_data_q;
  assign busy_o           = (state_q != S_IDLE);
  assign coef_err_o       = coef_err_q;

  // Operand select for the current tap; feedback taps are subtracted.
  always_comb begin
    mac_x = x_q;
    unique case (tap_q)
      3'd1:    mac_x = x1_q[sec_q];
      3'd2:    mac_x = x2_q[sec_q];
      3'd3:    mac_x = y1_q[sec_q];
      3'd4:    mac_x = y2_q[sec_q];
      default: mac_x = x_q;
    endcase
    mac_c    = coef_q[coef_idx];
    prod     = PROD_W'(mac_x) * PROD_W'(mac_c);
    prod_ext = ACC_W'(prod);
    acc_d    = (tap_q < 3'd3) ? (acc_q + prod_ext) : (acc_q - prod_ext);
  end

  assign shifted = acc_q >>> COEF_FRAC;

`ifdef IIR_SAT_EN
  // Clamp the shifted accumulator into the signed DATA_W range.
  always_comb begin
    y_nar = shifted[DATA_W-1:0];
    if (!(&shifted[ACC_W-1:DATA_W-1]) && (|shifted[ACC_W-1:DATA_W-1])) begin
      y_nar = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_shift_bits;
  assign unused_shift_bits = ^shifted[ACC_W-1:DATA_W];
  assign y_nar = shifted[DATA_W-1:0];
`endif

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: accept, 5 taps, write-back per section, then hold output.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (s_if.in_valid_i) state_d = S_MAC;
      S_MAC:   if (tap_q == 3'd4) state_d = S_WB;
      S_WB:    state_d = last_sec ? S_OUT : S_MAC;
      S_OUT:   if (s_if.out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficient store: writes only in IDLE without a colliding sample.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      coef_err_q <= 1'b0;
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= default_coef(i);
    end else begin
      coef_err_q <= coef_we_i && !coef_ok;
      if (coef_ok) coef_q[coef_addr_i] <= coef_data_i;
    end
  end

  // Datapath: sample capture, accumulation, write-back and section history.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sec_q      <= '0;
      tap_q      <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clear_i) begin
            for (int s = 0; s < NUM_SECTIONS; s++) begin
              x1_q[s] <= '0;
              x2_q[s] <= '0;
              y1_q[s] <= '0;
              y2_q[s] <= '0;
            end
          end
          if (s_if.in_valid_i) begin
            x_q   <= s_if.in_data_i;
            acc_q <= '0;
            sec_q <= '0;
            tap_q <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + 3'd1;
        end
        S_WB: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= y_nar;
          x_q         <= y_nar;
          acc_q       <= '0;
          tap_q       <= '0;
          if (last_sec) out_data_q <= y_nar;
          else          sec_q      <= sec_q + SEC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench for iir_biquad_cascade: a 1-section and a 2-section
// instance, directed vectors, and an arithmetic reference model of the cascade.
`timescale 1ns/1ps
module tb_iir_biquad_cascade;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int CF = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_i;
  logic          clear1, clear2, we1, we2;
  logic [2:0]    addr1;
  logic [3:0]    addr2;
  logic [CW-1:0] cdata1, cdata2;
  logic          err1, err2, busy1, busy2;

  iir_biquad_cascade_if #(.DATA_W(DW)) bus1 ();
  iir_biquad_cascade_if #(.DATA_W(DW)) bus2 ();

  iir_biquad_cascade #(.DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF), .NUM_SECTIONS(1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear1), .s_if(bus1),
    .coef_we_i(we1), .coef_addr_i(addr1), .coef_data_i(cdata1),
    .coef_err_o(err1), .busy_o(busy1));

  iir_biquad_cascade #(.DATA_W(DW), .COEF_W(CW), .COEF_FRAC(CF), .NUM_SECTIONS(2)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear2), .s_if(bus2),
    .coef_we_i(we2), .coef_addr_i(addr2), .coef_data_i(cdata2),
    .coef_err_o(err2), .busy_o(busy2));

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endfunction

  // ---------------- reference model ----------------
  longint mcoef [2][10];
  longint mx1 [2][2];
  longint mx2 [2][2];
  longint my1 [2][2];
  longint my2 [2][2];
  int     ns_of [2] = '{1, 2};
  longint exp0 [$];
  longint exp1 [$];
  longint e_val;

  function automatic longint sext(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint narrow(input longint v);
`ifdef IIR_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return longint'(t);
`endif
  endfunction

  function automatic void model_clear(input int d);
    for (int s = 0; s < 2; s++) begin
      mx1[d][s] = 0; mx2[d][s] = 0; my1[d][s] = 0; my2[d][s] = 0;
    end
  endfunction

  function automatic void model_reset(input int d);
    for (int s = 0; s < 2; s++) begin
      mcoef[d][s*5+0] = sext(32'h0001_0000);
      mcoef[d][s*5+1] = sext(32'hFFFE_1917);
      mcoef[d][s*5+2] = sext(32'h0001_0000);
      mcoef[d][s*5+3] = sext(32'hFFFE_1DF4);
      mcoef[d][s*5+4] = sext(32'h0000_FAE7);
    end
    model_clear(d);
  endfunction

  function automatic longint model_run(input int d, input longint x);
    longint v, acc, y;
    v = x;
    for (int s = 0; s < ns_of[d]; s++) begin
      acc = mcoef[d][s*5+0] * v + mcoef[d][s*5+1] * mx1[d][s] + mcoef[d][s*5+2] * mx2[d][s]
          - mcoef[d][s*5+3] * my1[d][s] - mcoef[d][s*5+4] * my2[d][s];
      y = narrow(acc >>> CF);
      mx2[d][s] = mx1[d][s]; mx1[d][s] = v;
      my2[d][s] = my1[d][s]; my1[d][s] = y;
      v = y;
    end
    return v;
  endfunction

  // ---------------- DUT access helpers ----------------
  function automatic logic rdy(input int d);
    return (d == 0) ? bus1.in_ready_o : bus2.in_ready_o;
  endfunction
  function automatic logic ovld(input int d);
    return (d == 0) ? bus1.out_valid_o : bus2.out_valid_o;
  endfunction
  function automatic logic ordy(input int d);
    return (d == 0) ? bus1.out_ready_i : bus2.out_ready_i;
  endfunction
  function automatic longint odata(input int d);
    return (d == 0) ? longint'($signed(bus1.out_data_o)) : longint'($signed(bus2.out_data_o));
  endfunction

  task automatic drive_in(input int d, input logic v, input logic [DW-1:0] x, input logic clr);
    if (d == 0) begin bus1.in_valid_i = v; bus1.in_data_i = x; clear1 = clr; end
    else        begin bus2.in_valid_i = v; bus2.in_data_i = x; clear2 = clr; end
  endtask

  // Send one sample (optionally with clear), check latency, return the output.
  task automatic send(input int d, input longint x, input logic clr, output longint got);
    int n;
    @(negedge clk_i);
    check("in_ready_idle", rdy(d), 1);
    drive_in(d, 1'b1, DW'(x), clr);
    @(posedge clk_i);
    if (clr) model_clear(d);
    if (d == 0) exp0.push_back(model_run(0, x));
    else        exp1.push_back(model_run(1, x));
    @(negedge clk_i);
    drive_in(d, 1'b0, '0, 1'b0);
    check("in_ready_low_after_accept", rdy(d), 0);
    n = 0;
    while (!ovld(d) && n < 100) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
    end
    check("latency", n, 6 * ns_of[d]);
    got = odata(d);
    if (ordy(d)) @(posedge clk_i);
  endtask

  task automatic wcoef(input int d, input int addr, input logic [31:0] val, input logic exp_err);
    @(negedge clk_i);
    if (d == 0) begin we1 = 1'b1; addr1 = 3'(addr); cdata1 = val; end
    else        begin we2 = 1'b1; addr2 = 4'(addr); cdata2 = val; end
    @(negedge clk_i);
    if (d == 0) we1 = 1'b0; else we2 = 1'b0;
    check("coef_err_pulse", (d == 0) ? err1 : err2, exp_err);
    @(negedge clk_i);
    check("coef_err_single_cycle", (d == 0) ? err1 : err2, 0);
    if (!exp_err) mcoef[d][addr] = sext(val);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (reset_i === 1'b1) begin
      check("busy1_is_not_ready", busy1, !bus1.in_ready_o);
      check("busy2_is_not_ready", busy2, !bus2.in_ready_o);
      if (bus1.out_valid_o && bus1.out_ready_i) begin
        check("dut1_expected_pending", exp0.size() > 0, 1);
        if (exp0.size() > 0) begin
          e_val = exp0.pop_front();
          $display("dut1 out=%0d model=%0d", odata(0), e_val);
          check("dut1_out_data", odata(0), e_val);
        end
      end
      if (bus2.out_valid_o && bus2.out_ready_i) begin
        check("dut2_expected_pending", exp1.size() > 0, 1);
        if (exp1.size() > 0) begin
          e_val = exp1.pop_front();
          $display("dut2 out=%0d model=%0d", odata(1), e_val);
          check("dut2_out_data", odata(1), e_val);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    longint g;
    reset_i = 1'b0;
    drive_in(0, 1'b0, '0, 1'b0);
    drive_in(1, 1'b0, '0, 1'b0);
    bus1.out_ready_i = 1'b1; bus2.out_ready_i = 1'b1;
    we1 = 1'b0; we2 = 1'b0; addr1 = '0; addr2 = '0; cdata1 = '0; cdata2 = '0;
    model_reset(0); model_reset(1);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_in_ready", bus1.in_ready_o, 1);
    check("rst_out_valid", bus1.out_valid_o, 0);
    check("rst_out_data", odata(0), 0);
    check("rst_coef_err", err1, 0);
    check("rst_busy", busy1, 0);
    check("rst_in_ready2", bus2.in_ready_o, 1);
    reset_i = 1'b1;

    // Impulse, default notch, one section: 1000, -19, -16
    send(0, 1000, 1'b0, g); check("imp1_y0", g, 1000);
    send(0, 0,    1'b0, g); check("imp1_y1", g, -19);
    send(0, 0,    1'b0, g); check("imp1_y2", g, -16);

    // Impulse, two sections: 1000, -38, then model
    send(1, 1000, 1'b0, g); check("imp2_y0", g, 1000);
    send(1, 0,    1'b0, g); check("imp2_y1", g, -38);
    send(1, 0,    1'b0, g);

    // Coefficient write while busy is rejected and leaves coefficients alone
    fork
      send(0, 1000, 1'b1, g);
      begin
        repeat (2) @(negedge clk_i);
        check("busy_during_write", busy1, 1);
        wcoef(0, 1, 32'h0000_0000, 1'b1);
      end
    join
    check("busy_write_y0", g, 1000);
    send(0, 0, 1'b0, g); check("busy_write_y1", g, -19);

    // Out-of-range address
    wcoef(0, 5, 32'h0000_1234, 1'b1);

    // Pass-through
    wcoef(0, 0, 32'h0001_0000, 1'b0);
    for (int i = 1; i < 5; i++) wcoef(0, i, 32'h0, 1'b0);
    send(0, 100, 1'b1, g); check("passthru", g, 100);

    // Overflow on narrowing
    wcoef(0, 0, 32'h0002_0000, 1'b0);
    send(0, 20000, 1'b0, g);
`ifdef IIR_SAT_EN
    check("overflow_sat", g, 32767);
`else
    check("overflow_wrap", g, -25536);
`endif

    // Restore notch defaults
    wcoef(0, 0, 32'h0001_0000, 1'b0);
    wcoef(0, 1, 32'hFFFE_1917, 1'b0);
    wcoef(0, 2, 32'h0001_0000, 1'b0);
    wcoef(0, 3, 32'hFFFE_1DF4, 1'b0);
    wcoef(0, 4, 32'h0000_FAE7, 1'b0);

    // Backpressure: output held for 10 cycles
    bus1.out_ready_i = 1'b0;
    send(0, 500, 1'b0, g);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_data_stable", odata(0), exp0[0]);
      check("bp_valid_held", bus1.out_valid_o, 1);
      check("bp_in_ready_low", bus1.in_ready_o, 0);
    end
    @(posedge clk_i);
    #1 bus1.out_ready_i = 1'b1;
    @(posedge clk_i);

    // Clear coincident with a sample: processed with zero history
    send(0, 1000, 1'b1, g); check("clear_y0", g, 1000);
    send(0, 0,    1'b0, g); check("clear_y1", g, -19);

    // Reset during MAC discards the sample and restores defaults
    wcoef(0, 0, 32'h0002_0000, 1'b0);
    @(negedge clk_i);
    drive_in(0, 1'b1, 16'd1234, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    drive_in(0, 1'b0, '0, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("midrst_out_valid", bus1.out_valid_o, 0);
    check("midrst_in_ready", bus1.in_ready_o, 1);
    check("midrst_out_data", odata(0), 0);
    reset_i = 1'b1;
    model_reset(0); model_reset(1);
    send(0, 1000, 1'b0, g); check("midrst_y0", g, 1000);
    send(0, 0,    1'b0, g); check("midrst_y1", g, -19);

    repeat (3) @(negedge clk_i);
    check("dut1_queue_drained", exp0.size(), 0);
    check("dut2_queue_drained", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised cascade of NUM_SECTIONS second-order IIR sections (Direct Form I), computed by a single time-shared multiply-accumulate engine under valid/ready handshakes on sample input and output. It succeeds the single-section notch filter in the DEM-DAC noise-shaping path. It adds run-time programmable coefficients, per-section history, a history-clear command, and selectable output saturation. Sits between the sample source and the DEM switch-block front end.

## Interface
- DATA_W, 16, sample width (signed integer samples)
- COEF_W, 32, coefficient width (signed, two's complement)
- COEF_FRAC, 16, coefficient fractional bits (Q16.16 by default)
- NUM_SECTIONS, 2, number of cascaded biquads (1..8)
- clk_i  in  1  single clock; all logic on rising edge
- reset_i  in  1  synchronous, active-low reset
- clear_i  in  1  synchronous flush of all section history; honoured only in IDLE, ignored otherwise
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  block can accept a sample
- in_data_i  in  DATA_W  input sample
- out_valid_o  out  1  output sample valid
- out_ready_i  in  1  downstream accepts output
- out_data_o  out  DATA_W  filtered sample
- coef_we_i  in  1  coefficient write strobe
- coef_addr_i  in  $clog2(5*NUM_SECTIONS)  address = section*5 + idx (0=b0, 1=b1, 2=b2, 3=a1, 4=a2)
- coef_data_i  in  COEF_W  coefficient value
- coef_err_o  out  1  one-cycle pulse when a write is rejected
- busy_o  out  1  high in any state other than IDLE

## Operation
- Each section computes y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2. The output of section s is the input x of section s+1. The output of the last section goes to out_data_o.
- Arithmetic:
  - Each product is DATA_W+COEF_W bits.
  - The accumulator is DATA_W+COEF_W+3 bits and never overflows for 5 terms.
  - Result = accumulator arithmetically shifted right by COEF_FRAC (truncate toward −inf), then narrowed to DATA_W as described under Configuration.
- State per section: x1, x2, y1, y2 (DATA_W each). They update at the end of that section's computation: x2←x1, x1←x, y2←y1, y1←y.
- FSM:
  - IDLE: in_ready_o=1. A handshake latches in_data_i, clears the accumulator, sets section=0, tap=0, and moves to MAC.
  - MAC: one multiply-accumulate per cycle, taps 0..4 in order b0, b1, b2, a1, a2. After tap 4, moves to WB.
  - WB: narrows the result, updates that section's history, and forwards the result as the next section's x.
    - If section < NUM_SECTIONS−1: section++, go to MAC.
    - Otherwise: load out_data_o, assert out_valid_o, go to OUT.
  - OUT: hold out_data_o and out_valid_o until out_ready_i=1, then go to IDLE.
- Coefficient writes:
  - Accepted only in IDLE, and only when no input handshake occurs in the same cycle. The new value is used from the next accepted sample onward.
  - A write in any other state, or one colliding with an input handshake, is dropped and coef_err_o pulses the next cycle.
  - An address ≥ 5·NUM_SECTIONS is dropped and also pulses coef_err_o.
- clear_i in IDLE zeroes all history on the next edge. If it coincides with an input handshake, the clear takes effect first and the sample is processed with zero history.
- Reset (reset_i=0 at a rising edge):
  - Outputs: in_ready_o=1, out_valid_o=0, out_data_o=0, coef_err_o=0, busy_o=0, FSM=IDLE.
  - All history is zeroed.
  - Every section's coefficients load the notch defaults: b0=0x00010000 (1.0), b1=0xFFFE1917 (−1.902), b2=0x00010000, a1=0xFFFE1DF4 (−1.883), a2=0x0000FAE7 (0.9801).
  - Reset mid-computation discards the sample; no partial output is produced.

## Timing
- Acceptance edge = cycle 0. out_valid_o rises at cycle 6·NUM_SECTIONS: 5 MAC cycles + 1 WB cycle per section.
- in_ready_o is low from cycle 1 until the cycle after the output handshake. Minimum sample period = 6·NUM_SECTIONS+1 cycles.
- Under backpressure (out_ready_i=0), out_data_o and out_valid_o stay stable and no history changes.
- coef_err_o is a registered single-cycle pulse. busy_o equals !in_ready_o.

## Configuration
- IIR_SAT_EN defined: narrowing clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1], both per section and at the output.
- IIR_SAT_EN undefined: narrowing keeps the low DATA_W bits (two's-complement wrap).

## Test plan
- Settings for all scenarios unless stated: NUM_SECTIONS=1, DATA_W=16.
- Pass-through: write b0=0x00010000 and b1=b2=a1=a2=0, send 100 → out_data_o=100 with out_valid_o rising exactly 6 cycles after acceptance.
- Impulse with default coefficients: send 1000, 0, 0 → outputs 1000, −19, then the value matching a bit-exact reference model. Repeat with NUM_SECTIONS=2 and check latency 12 cycles.
- Overflow: set b0=0x00020000, send 20000 → 32767 with IIR_SAT_EN defined, −25536 without.
- Coefficient write while busy_o=1 → coef_err_o pulses once and the next output is unchanged from the default-coefficient result. Write to address 5 (NUM_SECTIONS=1) → coef_err_o pulse.
- Backpressure and clear:
  - Hold out_ready_i=0 for 10 cycles → out_data_o stable and in_ready_o=0 throughout.
  - Then assert clear_i in IDLE and resend 1000 → first output 1000, matching a post-reset response.
- Reset mid-MAC: drive reset_i=0 at cycle 3 → next cycle out_valid_o=0 and in_ready_o=1, and history and coefficients are back to their defaults.
